// File: rtl/tcore_param.sv
// tcore_param: shared core parameters for the trap path.
//   XLEN              - datapath width
//   exc_type_e        - exception code reported by the execute stage
//   trap_state_e      - trap_controller sequencing states
//   CSR_*             - machine CSR addresses used by the trap sequence
//   exc_to_cause      - exception type to mcause value
//   trap_mstatus / mret_mstatus - mstatus updates on trap entry and MRET
package tcore_param;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    NO_EXCEPTION       = 4'd0,
    INSTR_MISALIGNED   = 4'd1,
    INSTR_ACCESS_FAULT = 4'd2,
    ILLEGAL_INSTR      = 4'd3,
    BREAKPOINT         = 4'd4,
    LOAD_MISALIGNED    = 4'd5,
    LOAD_ACCESS_FAULT  = 4'd6,
    STORE_MISALIGNED   = 4'd7,
    STORE_ACCESS_FAULT = 4'd8,
    ECALL_M            = 4'd9
  } exc_type_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_EPC    = 3'd1,
    WR_CAUSE  = 3'd2,
    WR_STATUS = 3'd3,
    MR_STATUS = 3'd4,
    REDIRECT  = 3'd5
  } trap_state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [XLEN-1:0] IRQ_CAUSE  = 32'h8000_000B;
  localparam logic [XLEN-1:0] EPC_MASK   = 32'hFFFF_FFFE;
  localparam logic [XLEN-1:0] MTVEC_MASK = 32'hFFFF_FFFC;

  // RISC-V privileged exception codes.
  function automatic logic [XLEN-1:0] exc_to_cause(input exc_type_e exc);
    case (exc)
      INSTR_MISALIGNED:   exc_to_cause = 32'd0;
      INSTR_ACCESS_FAULT: exc_to_cause = 32'd1;
      ILLEGAL_INSTR:      exc_to_cause = 32'd2;
      BREAKPOINT:         exc_to_cause = 32'd3;
      LOAD_MISALIGNED:    exc_to_cause = 32'd4;
      LOAD_ACCESS_FAULT:  exc_to_cause = 32'd5;
      STORE_MISALIGNED:   exc_to_cause = 32'd6;
      STORE_ACCESS_FAULT: exc_to_cause = 32'd7;
      ECALL_M:            exc_to_cause = 32'd11;
      default:            exc_to_cause = 32'd0;
    endcase
  endfunction

  // Trap entry: MPIE <= MIE (bit 3 -> bit 7), MIE <= 0, MPP <= M.
  function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r        = ms;
    r[7]     = ms[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // MRET: MIE <= MPIE, MPIE <= 1, MPP <= M (M-mode only core).
  function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r        = ms;
    r[3]     = ms[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap / MRET sequencer.
// Accepts an exception or enabled external interrupt (or MRET) from the
// execute stage, flushes the front end, writes mepc/mcause/mstatus over
// one CSR write port (one CSR per cycle), then issues a fetch redirect.
// Ports:
//   clk_i, rst_ni                         clock, async active-low reset
//   ex_valid_i, ex_pc_i, ex_exc_type_i    execute-stage instruction info
//   ex_mret_i, irq_i                      MRET flag, external interrupt
//   ex_csr_wr_en_i/idx_i/wdata_i          pipeline CSR write request
//   mtvec_i, mepc_i, mstatus_i            current CSR values
//   csr_wr_en_o/idx_o/wdata_o             arbitrated CSR write port
//   flush_o, stall_o                      pipeline control
//   redirect_valid_o, redirect_pc_o       one-cycle fetch redirect
module trap_controller
  import tcore_param::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  exc_type_e       ex_exc_type_i,
  input  logic            ex_mret_i,
  input  logic            irq_i,
  input  logic            ex_csr_wr_en_i,
  input  logic [11:0]     ex_csr_idx_i,
  input  logic [XLEN-1:0] ex_csr_wdata_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [XLEN-1:0] mstatus_i,
  output logic            csr_wr_en_o,
  output logic [11:0]     csr_idx_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            flush_o,
  output logic            stall_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  trap_state_e     state, state_next;
  logic [XLEN-1:0] pc_q, cause_q;
  logic            mret_q;
  logic            trap_accept, mret_accept;

  // State register and trap context capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      pc_q    <= 32'd0;
      cause_q <= 32'd0;
      mret_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (trap_accept) begin
        pc_q    <= ex_pc_i & EPC_MASK;
        cause_q <= (ex_exc_type_i != NO_EXCEPTION) ? exc_to_cause(ex_exc_type_i) : IRQ_CAUSE;
        mret_q  <= 1'b0;
      end else if (mret_accept) begin
        mret_q <= 1'b1;
      end else begin
        mret_q <= mret_q;
      end
    end
  end

  // Accept decode, next state, CSR port arbitration and pipeline control.
  always_comb begin
    state_next       = state;
    trap_accept      = 1'b0;
    mret_accept      = 1'b0;
    flush_o          = 1'b0;
    stall_o          = 1'b0;
    csr_wr_en_o      = 1'b0;
    csr_idx_o        = 12'd0;
    csr_wdata_o      = 32'd0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = 32'd0;
    case (state)
      IDLE: begin
        // Outputs stay quiet while reset is held, even with live inputs.
        if (rst_ni && ex_valid_i &&
            ((ex_exc_type_i != NO_EXCEPTION) || (irq_i && mstatus_i[3]))) begin
          trap_accept = 1'b1;
          flush_o     = 1'b1;
          state_next  = WR_EPC;
        end else if (rst_ni && ex_valid_i && ex_mret_i) begin
          mret_accept = 1'b1;
          flush_o     = 1'b1;
          state_next  = MR_STATUS;
        end else if (rst_ni && ex_csr_wr_en_i) begin
          csr_wr_en_o = 1'b1;
          csr_idx_o   = ex_csr_idx_i;
          csr_wdata_o = ex_csr_wdata_i;
        end else begin
          state_next = IDLE;
        end
      end
      WR_EPC: begin
        stall_o     = 1'b1;
        csr_wr_en_o = 1'b1;
        csr_idx_o   = CSR_MEPC;
        csr_wdata_o = pc_q;
        state_next  = WR_CAUSE;
      end
      WR_CAUSE: begin
        stall_o     = 1'b1;
        csr_wr_en_o = 1'b1;
        csr_idx_o   = CSR_MCAUSE;
        csr_wdata_o = cause_q;
        state_next  = WR_STATUS;
      end
      WR_STATUS: begin
        stall_o     = 1'b1;
        csr_wr_en_o = 1'b1;
        csr_idx_o   = CSR_MSTATUS;
        csr_wdata_o = trap_mstatus(mstatus_i);
        state_next  = REDIRECT;
      end
      MR_STATUS: begin
        stall_o     = 1'b1;
        csr_wr_en_o = 1'b1;
        csr_idx_o   = CSR_MSTATUS;
        csr_wdata_o = mret_mstatus(mstatus_i);
        state_next  = REDIRECT;
      end
      REDIRECT: begin
        stall_o          = 1'b1;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = mret_q ? mepc_i : (mtvec_i & MTVEC_MASK);
        state_next       = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: doc/trap_controller.md
TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 Parameters: none; XLEN and exc_type_e SHALL come from tcore_param.
REQ-002 clk_i  in  1  clock; all state on rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 ex_valid_i  in  1  execute stage holds a valid, non-stalled instruction this cycle.
REQ-005 ex_pc_i  in  XLEN  PC of that instruction.
REQ-006 ex_exc_type_i  in  exc_type_e  exception raised in execute; NO_EXCEPTION if none.
REQ-007 ex_mret_i  in  1  instruction is MRET.
REQ-008 irq_i  in  1  machine external interrupt pending (level).
REQ-009 ex_csr_wr_en_i / ex_csr_idx_i / ex_csr_wdata_i  in  1/12/XLEN  pipeline CSR write request.
REQ-010 mtvec_i / mepc_i / mstatus_i  in  XLEN each  current CSR values.
REQ-011 csr_wr_en_o / csr_idx_o / csr_wdata_o  out  1/12/XLEN  arbitrated CSR write port.
REQ-012 flush_o  out  1  kill IF/ID/EX contents this cycle.
REQ-013 stall_o  out  1  hold the front end; the execute stage does not advance.
REQ-014 redirect_valid_o / redirect_pc_o  out  1/XLEN  one-cycle fetch redirect.

Function
REQ-015 FSM states: IDLE, WR_EPC, WR_CAUSE, WR_STATUS, REDIRECT; MRET path IDLE -> MR_STATUS -> REDIRECT.
REQ-016 Trap accept in IDLE: ex_valid_i and (ex_exc_type_i != NO_EXCEPTION or (irq_i and mstatus_i[3])).
REQ-017 Exception SHALL take priority over interrupt; either trap SHALL take priority over ex_mret_i.
REQ-018 On accept (cycle N), assert flush_o combinationally and register pc=ex_pc_i and cause; next state WR_EPC.
REQ-019 Cause: exception -> exc_to_cause(ex_exc_type_i), with INSTR_MISALIGNED=0 and other members at their RISC-V privileged codes; interrupt -> 32'h8000_000B.
REQ-020 WR_EPC (N+1): write 12'h341 <= {pc[XLEN-1:1],1'b0}.
REQ-021 WR_CAUSE (N+2): write 12'h342 <= cause.
REQ-022 WR_STATUS (N+3): write 12'h300 <= mstatus_i with MPIE=MIE, MIE=0, MPP=2'b11.
REQ-023 REDIRECT (N+4): redirect_valid_o=1, redirect_pc_o={mtvec_i[XLEN-1:2],2'b00} (direct mode only); next IDLE.
REQ-024 MRET accept (IDLE, ex_valid_i, ex_mret_i, no trap): flush_o=1; MR_STATUS writes 12'h300 with MIE=MPIE, MPIE=1, MPP=2'b11; REDIRECT drives redirect_pc_o=mepc_i.
REQ-025 stall_o SHALL be 1 in every state except IDLE; flush_o SHALL be 0 outside the accept cycle.
REQ-026 CSR arbitration: in IDLE with no accept, pass ex_csr_* straight through combinationally; on an accept cycle or in any non-IDLE state, drop the pipeline request and drive only the FSM write.
REQ-027 A pipeline CSR write that coincides with a trap accept SHALL be discarded; the instruction is flushed.
REQ-028 Inputs other than mtvec_i, mepc_i and mstatus_i SHALL be ignored outside IDLE; irq_i raised mid-sequence SHALL be evaluated only on return to IDLE.
REQ-029 csr_wr_en_o SHALL be high for exactly one cycle per FSM write state; unused outputs SHALL be driven to 0.

Reset
REQ-030 Asynchronous reset SHALL force state=IDLE, captured pc/cause=0, and all outputs to 0, including mid-sequence; the aborted trap SHALL NOT resume.

Structure
REQ-031 trap_state_e, the CSR address constants (MSTATUS/MEPC/MCAUSE/MTVEC) and function exc_to_cause SHALL live in tcore_param.
REQ-032 trap_controller SHALL be a single module with no sub-module; it sits beside stage3_execution and its CSR port feeds cs_reg_file.

Verification
REQ-033 ex_valid_i=1, ex_pc_i=32'h0000_0104, INSTR_MISALIGNED, mtvec_i=32'h0000_0200 -> flush_o at N; writes 341<=104, 342<=0, 300 (MIE 0) at N+1..N+3; redirect to 32'h200 at N+4.
REQ-034 irq_i=1, mstatus_i=32'h8, ex_pc_i=32'h0000_0040 -> mcause written 32'h8000_000B, mstatus written 32'h1880; with mstatus_i=0 -> no accept.
REQ-035 ex_mret_i=1, mepc_i=32'h0000_0300, mstatus_i=32'h80 -> mstatus written 32'h1888; redirect_pc_o=32'h300 two cycles after accept.
REQ-036 Exception together with ex_csr_wr_en_i=1 (idx 12'h340) -> no write to 12'h340 on any cycle; trap writes only.
REQ-037 rst_ni low during WR_CAUSE -> outputs 0 immediately; after release, with no new request, no redirect and no further CSR writes occur.
